mem_access_ctrl: RTL and testbench

Initiator-side controller that drives the word-organised data memory on behalf of the MEM pipeline stage. It accepts load/store requests through a valid/ready handshake and issues word-aligned read and write cycles. It performs read-modify-write for byte/halfword stores and returns sign- or zero-extended load data with a single-cycle response pulse. It sits between the MEM stage and the data memory, and is the only block that asserts the memory's write and read enables.

---
 rtl/mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Drives the word-organised, big-endian data memory on behalf of the MEM
//   pipeline stage. Accepts one load/store at a time through a valid/ready
//   handshake. Sub-word stores are done as read-modify-write. Loads return
//   the addressed lane, right-justified and sign- or zero-extended. Every
//   request ends with a single-cycle response pulse.
//
//   Build option: MEM_CTRL_SUBWORD_EN
//     defined   - byte and halfword loads/stores are supported.
//     undefined - only word accesses are legal; byte/halfword sizes are
//                 reported as errors, and the merge and extract logic is
//                 not built.
//
//   Ports
//     clk, rst                    clock, synchronous active-high reset
//     req_valid / req_ready       request handshake (ready only in IDLE)
//     req_write, req_size,        request fields; size 00 byte, 01 half,
//     req_signed, req_addr,       10 word, 11 reserved
//     req_wdata
//     resp_valid, resp_err,       one-cycle completion pulse with status and
//     resp_rdata                  load data (rdata is 0 for stores/errors)
//     mem_readEn, mem_writeEn,    memory strobes, word-aligned address and
//     mem_address, mem_dataIn     write word (address/data 0 when idle)
//     mem_dataOut                 combinational read word from memory
module mem_access_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_writeEn,
  output logic              mem_readEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_dataIn,
  input  logic [31:0]       mem_dataOut
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              write_reg;
  logic              err_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       word_reg;     // word captured at the end of READ
  logic              req_err;
  logic              accept;
  logic [31:0]       store_word;   // word presented during WRITE
  logic [31:0]       load_word;    // extended load result

  assign accept = req_valid & (state_reg == ST_IDLE);

  // Request legality, evaluated on the live request inputs in IDLE.
  always_comb begin
    req_err = 1'b0;
    if (req_addr >= MEM_LIMIT) begin
      req_err = 1'b1;
    end
    case (req_size)
      SZ_WORD: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
`ifdef MEM_CTRL_SUBWORD_EN
      SZ_HALF: if (req_addr[0]) req_err = 1'b1;
      SZ_BYTE: ;
`else
      SZ_HALF, SZ_BYTE: req_err = 1'b1;
`endif
      default: req_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request latch and read-word capture. Inputs are ignored outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
      wdata_reg <= '0;
      word_reg  <= '0;
    end else begin
      if (accept) begin
        addr_reg  <= req_addr;
        write_reg <= req_write;
        err_reg   <= req_err;
        wdata_reg <= req_wdata;
      end
      if (state_reg == ST_READ) begin
        word_reg <= mem_dataOut;
      end
    end
  end

`ifdef MEM_CTRL_SUBWORD_EN
  logic [1:0] size_reg;
  logic       signed_reg;
  logic [7:0] rd_byte [4];
  logic [31:0] merge_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      size_reg   <= 2'b00;
      signed_reg <= 1'b0;
    end else if (accept) begin
      size_reg   <= req_size;
      signed_reg <= req_signed;
    end
  end

  // Byte lane gi sits at bits [31-8*gi -: 8] (big-endian within the word).
  // A halfword covers lanes {0,1} or {2,3}; its high byte is the even lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       lane_hit;
    logic [7:0] new_byte;

    assign rd_byte[gi] = word_reg[31-8*gi -: 8];
    assign lane_hit = (size_reg == SZ_HALF) ? (addr_reg[1] == LANE[1])
                                            : (addr_reg[1:0] == LANE);
    assign new_byte = (size_reg == SZ_HALF && !LANE[0]) ? wdata_reg[15:8]
                                                        : wdata_reg[7:0];
    assign merge_word[31-8*gi -: 8] = lane_hit ? new_byte : rd_byte[gi];
  end

  assign store_word = (size_reg == SZ_WORD) ? wdata_reg : merge_word;

  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    sel_byte  = rd_byte[addr_reg[1:0]];
    sel_half  = addr_reg[1] ? word_reg[15:0] : word_reg[31:16];
    load_word = word_reg;
    case (size_reg)
      SZ_BYTE: load_word = {{24{signed_reg & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_word = {{16{signed_reg & sel_half[15]}}, sel_half};
      default: load_word = word_reg;
    endcase
  end
`else
  // Word-only build: the low address bits and the extension flag carry no
  // information once a request has been judged legal.
  logic unused_nosub;
  assign unused_nosub = &{1'b0, req_signed, addr_reg[1:0]};

  assign store_word = wdata_reg;
  assign load_word  = word_reg;
`endif

  // Next state and outputs.
  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    mem_readEn  = 1'b0;
    mem_writeEn = 1'b0;
    mem_address = '0;
    mem_dataIn  = '0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_next = ST_RESP;
          end else if (req_write && req_size == SZ_WORD) begin
            state_next = ST_WRITE;
          end else begin
            // Loads, and sub-word stores that need the old word first.
            state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        mem_readEn  = 1'b1;
        mem_address = {addr_reg[ADDR_W-1:2], 2'b00};
`ifdef MEM_CTRL_SUBWORD_EN
        state_next  = write_reg ? ST_WRITE : ST_RESP;
`else
        state_next  = ST_RESP;
`endif
      end
      ST_WRITE: begin
        // A reset landing on this cycle must not commit the store.
        if (!rst) begin
          mem_writeEn = 1'b1;
          mem_address = {addr_reg[ADDR_W-1:2], 2'b00};
          mem_dataIn  = store_word;
        end
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        resp_rdata = (err_reg || write_reg) ? 32'h0 : load_word;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed requests against a behavioural
// 1 KiB word memory. Expected responses go into a queue when a request is
// accepted; a monitor pops and compares whenever resp_valid is seen.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_writeEn;
  logic        mem_readEn;
  logic [31:0] mem_address;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .mem_writeEn (mem_writeEn),
    .mem_readEn  (mem_readEn),
    .mem_address (mem_address),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut)
  );

  // Behavioural memory: combinational read, write on the clock edge.
  logic [31:0] mem [256];
  logic        init_mem = 1'b1;
  assign mem_dataOut = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h08] <= 32'h80F0_7F01;   // 0x20
      mem[8'h0C] <= 32'hCAFE_BABE;   // 0x30
      mem[8'hFF] <= 32'hDEAD_BEEF;   // 0x3FC
    end else if (mem_writeEn) begin
      mem[mem_address[9:2]] <= mem_dataIn;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int acc_cyc = 0;
  int cur_rd = 0;
  int cur_wr = 0;
  int resp_total = 0;
  int bus_bad = 0;
  int align_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: strobe bookkeeping every cycle, scoreboard compare on resp_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_readEn) cur_rd++;
      if (mem_writeEn) cur_wr++;
      if ((mem_readEn || mem_writeEn) && mem_address[1:0] != 2'b00) align_bad++;
      if (!mem_readEn && !mem_writeEn && (mem_address != 0 || mem_dataIn != 0)) bus_bad++;
      if (!resp_valid && (resp_err || resp_rdata != 0)) bus_bad++;
      if (resp_valid) begin
        resp_total++;
        check("resp_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          $display("resp %s: err=%0d rdata=0x%08h lat=%0d rd=%0d wr=%0d",
                   e.name, resp_err, resp_rdata, cyc - acc_cyc + 1, cur_rd, cur_wr);
          check({e.name, "_err"}, 32'(resp_err), 32'(e.err));
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          check({e.name, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(e.lat));
          check({e.name, "_reads"}, 32'(cur_rd), 32'(e.nrd));
          check({e.name, "_writes"}, 32'(cur_wr), 32'(e.nwr));
          check({e.name, "_ready_low"}, 32'(req_ready), 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd,
                       input int e_lat, input int e_nrd, input int e_nwr,
                       input string nm);
    exp_t e;
    int n;
    @(negedge clk);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cur_rd = 0;
    cur_wr = 0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    e.err = e_err; e.rdata = e_rd; e.lat = e_lat;
    e.nrd = e_nrd; e.nwr = e_nwr; e.name = nm;
    exp_q.push_back(e);
    for (int i = 0; i < 12; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check({nm, "_completed"}, 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  initial begin
    int resp_before;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    init_mem = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_strobes", 32'({mem_readEn, mem_writeEn}), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);

    //     wr   size   sgn  addr          wdata          err  rdata          lat rd wr name
    issue(1'b1, 2'b10, 1'b0, 32'h010, 32'h1122_3344, 1'b0, 32'h0,          2, 0, 1, "st_w_10");
    check("mem_10_after_store", mem[4], 32'h1122_3344);
    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0,         1'b0, 32'h1122_3344,  2, 1, 0, "ld_w_10");
    issue(1'b0, 2'b10, 1'b1, 32'h020, 32'h0,         1'b0, 32'h80F0_7F01,  2, 1, 0, "ld_w_20_sgn");
    issue(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,         1'b0, 32'hDEAD_BEEF,  2, 1, 0, "ld_w_3fc");

`ifdef MEM_CTRL_SUBWORD_EN
    issue(1'b1, 2'b00, 1'b0, 32'h012, 32'hFFFF_FFAB, 1'b0, 32'h0,          3, 1, 1, "st_b_12");
    check("mem_10_after_sb", mem[4], 32'h1122_AB44);
    issue(1'b1, 2'b01, 1'b0, 32'h012, 32'hFFFF_5566, 1'b0, 32'h0,          3, 1, 1, "st_h_12");
    check("mem_10_after_sh", mem[4], 32'h1122_5566);
    issue(1'b1, 2'b00, 1'b0, 32'h010, 32'h0000_0099, 1'b0, 32'h0,          3, 1, 1, "st_b_10");
    check("mem_10_after_sb0", mem[4], 32'h9922_5566);
    issue(1'b0, 2'b00, 1'b1, 32'h020, 32'h0,         1'b0, 32'hFFFF_FF80,  2, 1, 0, "ld_b_20_sgn");
    issue(1'b0, 2'b00, 1'b0, 32'h020, 32'h0,         1'b0, 32'h0000_0080,  2, 1, 0, "ld_b_20_uns");
    issue(1'b0, 2'b00, 1'b1, 32'h021, 32'h0,         1'b0, 32'hFFFF_FFF0,  2, 1, 0, "ld_b_21_sgn");
    issue(1'b0, 2'b00, 1'b0, 32'h023, 32'h0,         1'b0, 32'h0000_0001,  2, 1, 0, "ld_b_23_uns");
    issue(1'b0, 2'b01, 1'b1, 32'h022, 32'h0,         1'b0, 32'h0000_7F01,  2, 1, 0, "ld_h_22_sgn");
    issue(1'b0, 2'b01, 1'b1, 32'h020, 32'h0,         1'b0, 32'hFFFF_80F0,  2, 1, 0, "ld_h_20_sgn");
    issue(1'b0, 2'b01, 1'b0, 32'h020, 32'h0,         1'b0, 32'h0000_80F0,  2, 1, 0, "ld_h_20_uns");
    issue(1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0,         1'b0, 32'hFFFF_FFEF,  2, 1, 0, "ld_b_3ff_sgn");
`else
    issue(1'b0, 2'b00, 1'b0, 32'h010, 32'h0,         1'b1, 32'h0,          1, 0, 0, "ld_b_10_nosub");
    issue(1'b0, 2'b01, 1'b1, 32'h020, 32'h0,         1'b1, 32'h0,          1, 0, 0, "ld_h_20_nosub");
    issue(1'b1, 2'b00, 1'b0, 32'h010, 32'h0000_00AB, 1'b1, 32'h0,          1, 0, 0, "st_b_10_nosub");
    check("mem_10_after_nosub_sb", mem[4], 32'h1122_3344);
`endif

    // Error requests: no strobes, one-cycle response.
    issue(1'b0, 2'b10, 1'b0, 32'h006, 32'h0,         1'b1, 32'h0,          1, 0, 0, "err_ld_w_06");
    issue(1'b1, 2'b01, 1'b0, 32'h003, 32'h0000_1234, 1'b1, 32'h0,          1, 0, 0, "err_st_h_03");
    issue(1'b0, 2'b11, 1'b0, 32'h010, 32'h0,         1'b1, 32'h0,          1, 0, 0, "err_size_11");
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0,         1'b1, 32'h0,          1, 0, 0, "err_ld_400");
    issue(1'b1, 2'b10, 1'b0, 32'h400, 32'h5555_5555, 1'b1, 32'h0,          1, 0, 0, "err_st_400");

    // Reset landing on the WRITE cycle of a word store to 0x30.
    resp_before = resp_total;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h030; req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cur_wr = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    $display("reset during write issued");
    check("rstwr_ready", 32'(req_ready), 32'd1);
    check("rstwr_writes", 32'(cur_wr), 32'd0);
    repeat (4) @(negedge clk);
    check("rstwr_no_resp", 32'(resp_total), 32'(resp_before));
    check("rstwr_mem_30", mem[12], 32'hCAFE_BABE);
    issue(1'b0, 2'b10, 1'b0, 32'h030, 32'h0,         1'b0, 32'hCAFE_BABE,  2, 1, 0, "ld_w_30_after_rst");
    issue(1'b1, 2'b10, 1'b0, 32'h030, 32'h0BAD_F00D, 1'b0, 32'h0,          2, 0, 1, "st_w_30");
    check("mem_30_after_store", mem[12], 32'h0BAD_F00D);

    check("bus_idle_zero", 32'(bus_bad), 32'd0);
    check("addr_aligned", 32'(align_bad), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
